// File: rtl/ifu_jalr_rs1_ctrl_if.sv
// Signal bundle between the IFU mini-decode/BPU side, the IR/EXU operand read
// request and regfile read port 1, as seen by the JALR xN rs1 read controller.
interface ifu_jalr_rs1_ctrl_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RFIDX_WIDTH = 5
);
  // Mini-decode
  logic                   dec_i_valid;
  logic                   dec_jalr;
  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx;
  // IFU / BPU control
  logic                   bpu_dep;
  logic                   ifu_flush;
  logic                   ifu_accept;
  // IR/EXU competing read
  logic                   ir_rs1_req;
  logic [RFIDX_WIDTH-1:0] ir_rs1idx;
  // Regfile read port 1
  logic [XLEN-1:0]        rf_rd1_data;
  logic [RFIDX_WIDTH-1:0] rf_rd1_idx;
  // Controller results
  logic                   bpu_gnt;
  logic                   ir_rs1_stall;
  logic                   jalr_stall;
  logic                   bpu_rs1_vld;
  logic [XLEN-1:0]        bpu_rs1;

  // Controller side
  modport slave (
    input  dec_i_valid, dec_jalr, dec_jalr_rs1idx,
    input  bpu_dep, ifu_flush, ifu_accept,
    input  ir_rs1_req, ir_rs1idx,
    input  rf_rd1_data,
    output rf_rd1_idx, bpu_gnt, ir_rs1_stall, jalr_stall, bpu_rs1_vld, bpu_rs1
  );

  // Surrounding IFU / regfile side
  modport master (
    output dec_i_valid, dec_jalr, dec_jalr_rs1idx,
    output bpu_dep, ifu_flush, ifu_accept,
    output ir_rs1_req, ir_rs1idx,
    output rf_rd1_data,
    input  rf_rd1_idx, bpu_gnt, ir_rs1_stall, jalr_stall, bpu_rs1_vld, bpu_rs1
  );
endinterface

// File: rtl/ifu_jalr_rs1_ctrl.sv
// JALR xN rs1 read controller: waits out the xN dependency, wins regfile read
// port 1 from the IR/EXU (with anti-starvation), captures the value and holds it
// for the IFU next-PC adder until the IFU accepts it.
module ifu_jalr_rs1_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned STARVE_MAX  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  ifu_jalr_rs1_ctrl_if.slave  bus
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveLimit = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDep  = 2'd1,
    StArb  = 2'd2,
    StHold = 2'd3
  } state_e;

  state_e                 state;
  logic [CntW-1:0]        starve_cnt;
  logic [XLEN-1:0]        rs1_buf;
  logic                   rs1_vld;

  logic                   jalr_xn_req;
  logic                   in_arb;
  logic                   starved;
  logic                   gnt;

  // x0 and x1 are served by other paths; only xN needs the shared port.
  assign jalr_xn_req = bus.dec_i_valid & bus.dec_jalr
                     & (bus.dec_jalr_rs1idx != '0)
                     & (bus.dec_jalr_rs1idx != RFIDX_WIDTH'(1));

  assign in_arb  = (state == StArb);
  assign starved = (starve_cnt == StarveLimit);

  // BPU wins the port when IR is idle, or by force once IR has won too often.
  assign gnt = in_arb & (~bus.ir_rs1_req | starved);

  assign bus.bpu_gnt      = gnt;
  assign bus.rf_rd1_idx   = gnt ? bus.dec_jalr_rs1idx : bus.ir_rs1idx;
  assign bus.ir_rs1_stall = in_arb & bus.ir_rs1_req & starved;
  assign bus.jalr_stall   = ((state == StIdle) & jalr_xn_req) | (state == StDep) | in_arb;
  assign bus.bpu_rs1_vld  = rs1_vld;
  assign bus.bpu_rs1      = rs1_buf;

  // Sequencer: state, starvation counter, captured rs1 and its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      starve_cnt <= '0;
      rs1_buf    <= '0;
      rs1_vld    <= 1'b0;
    end else if (bus.ifu_flush) begin
      // Flush wins over everything, including a same-cycle grant or new request.
      state      <= StIdle;
      starve_cnt <= '0;
      rs1_vld    <= 1'b0;
    end else begin
      // Counter only lives in ARB; any other path leaves it cleared.
      starve_cnt <= '0;
      unique case (state)
        StIdle: begin
          rs1_vld <= 1'b0;
          if (jalr_xn_req) begin
            state <= bus.bpu_dep ? StDep : StArb;
          end
        end
        StDep: begin
          if (!bus.bpu_dep) begin
            state <= StArb;
          end
        end
        StArb: begin
          if (gnt) begin
            rs1_buf <= bus.rf_rd1_data;
            rs1_vld <= 1'b1;
            state   <= StHold;
          end else begin
            starve_cnt <= starved ? starve_cnt : starve_cnt + CntW'(1);
          end
        end
        StHold: begin
          if (bus.ifu_accept) begin
            rs1_vld <= 1'b0;
            state   <= StIdle;
          end
        end
        default: begin
          state   <= StIdle;
          rs1_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_jalr_rs1_ctrl.sv
// Directed bench for the JALR xN rs1 read controller with a transaction-level
// reference model and a per-cycle output compare.
module tb_ifu_jalr_rs1_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RW     = 5;
  localparam int unsigned STARVE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_jalr_rs1_ctrl_if #(.XLEN(XLEN), .RFIDX_WIDTH(RW)) bus_if ();

  ifu_jalr_rs1_ctrl #(
    .XLEN        (XLEN),
    .RFIDX_WIDTH (RW),
    .STARVE_MAX  (STARVE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  logic [XLEN-1:0] regs [32];
  assign bus_if.rf_rd1_data = regs[bus_if.rf_rd1_idx];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding JALR sequence described by flags.
  bit          m_active;
  bit          m_dep_wait;
  bit          m_have;
  int          m_lost;
  logic [31:0] m_val;

  logic        xn;
  logic        e_gnt, e_irst, e_jst;
  logic [4:0]  e_idx;

  always_comb begin
    xn     = bus_if.dec_i_valid && bus_if.dec_jalr && (bus_if.dec_jalr_rs1idx > 5'd1);
    e_gnt  = m_active && !m_dep_wait && !m_have && (!bus_if.ir_rs1_req || m_lost >= STARVE);
    e_irst = m_active && !m_dep_wait && !m_have && bus_if.ir_rs1_req && m_lost >= STARVE;
    e_idx  = e_gnt ? bus_if.dec_jalr_rs1idx : bus_if.ir_rs1idx;
    e_jst  = m_active ? !m_have : xn;
  end

  always @(posedge clk or negedge rst_n) begin
    bit g;
    if (!rst_n) begin
      m_active = 0; m_dep_wait = 0; m_have = 0; m_lost = 0; m_val = '0;
    end else begin
      g = m_active && !m_dep_wait && !m_have && (!bus_if.ir_rs1_req || m_lost >= STARVE);
      if (bus_if.ifu_flush) begin
        m_active = 0; m_dep_wait = 0; m_have = 0; m_lost = 0;
      end else if (!m_active) begin
        if (xn) begin
          m_active = 1; m_dep_wait = bus_if.bpu_dep; m_have = 0; m_lost = 0;
        end
      end else if (m_dep_wait) begin
        if (!bus_if.bpu_dep) m_dep_wait = 0;
      end else if (!m_have) begin
        if (g) begin
          m_have = 1; m_val = regs[bus_if.dec_jalr_rs1idx]; m_lost = 0;
        end else if (m_lost < STARVE) begin
          m_lost++;
        end
      end else if (bus_if.ifu_accept) begin
        m_active = 0; m_have = 0;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_bpu_gnt", 32'(bus_if.bpu_gnt), 32'(e_gnt));
      chk("cmp_rf_rd1_idx", 32'(bus_if.rf_rd1_idx), 32'(e_idx));
      chk("cmp_ir_rs1_stall", 32'(bus_if.ir_rs1_stall), 32'(e_irst));
      chk("cmp_jalr_stall", 32'(bus_if.jalr_stall), 32'(e_jst));
      chk("cmp_bpu_rs1_vld", 32'(bus_if.bpu_rs1_vld), 32'(m_have));
      if (m_have) chk("cmp_bpu_rs1", bus_if.bpu_rs1, m_val);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic j, input logic [4:0] idx);
    bus_if.dec_i_valid     = v;
    bus_if.dec_jalr        = j;
    bus_if.dec_jalr_rs1idx = idx;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0000 * i + 32'(i);
    regs[5]  = 32'h0000_1000;
    regs[7]  = 32'h7777_0007;
    regs[9]  = 32'h9999_0009;
    regs[12] = 32'hDEAD_BEEF;
    set_dec(0, 0, 0);
    bus_if.bpu_dep    = 0;
    bus_if.ifu_flush  = 0;
    bus_if.ifu_accept = 0;
    bus_if.ir_rs1_req = 0;
    bus_if.ir_rs1idx  = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus_if.bpu_gnt), 0);
    chk("rst_vld", 32'(bus_if.bpu_rs1_vld), 0);
    chk("rst_jst", 32'(bus_if.jalr_stall), 0);
    chk("rst_rs1", bus_if.bpu_rs1, 0);
    @(negedge clk);
    rst_n = 1;
    nxt();

    // Reach HOLD with 0xDEADBEEF, then reset asynchronously mid-cycle
    set_dec(1, 1, 12);
    @(negedge clk);
    nxt();
    @(negedge clk);
    chk("x12_gnt", 32'(bus_if.bpu_gnt), 1);
    nxt();
    set_dec(0, 0, 0);
    @(negedge clk);
    chk("x12_vld", 32'(bus_if.bpu_rs1_vld), 1);
    chk("x12_rs1", bus_if.bpu_rs1, 32'hDEAD_BEEF);
    #2;
    rst_n = 0;
    #1;
    chk("arst_vld", 32'(bus_if.bpu_rs1_vld), 0);
    chk("arst_rs1", bus_if.bpu_rs1, 0);
    chk("arst_gnt", 32'(bus_if.bpu_gnt), 0);
    chk("arst_irst", 32'(bus_if.ir_rs1_stall), 0);
    chk("arst_jst", 32'(bus_if.jalr_stall), 0);
    chk("arst_idx", 32'(bus_if.rf_rd1_idx), 0);
    @(negedge clk);
    rst_n = 1;
    nxt();

    // x5, no dependency, no contention
    bus_if.ir_rs1idx = 2;
    set_dec(1, 1, 5);
    @(negedge clk);
    chk("x5_T_jst", 32'(bus_if.jalr_stall), 1);
    chk("x5_T_gnt", 32'(bus_if.bpu_gnt), 0);
    nxt();
    @(negedge clk);
    chk("x5_T1_gnt", 32'(bus_if.bpu_gnt), 1);
    chk("x5_T1_idx", 32'(bus_if.rf_rd1_idx), 5);
    chk("x5_T1_jst", 32'(bus_if.jalr_stall), 1);
    nxt();
    set_dec(0, 0, 0);
    bus_if.ifu_accept = 1;
    @(negedge clk);
    chk("x5_T2_vld", 32'(bus_if.bpu_rs1_vld), 1);
    chk("x5_T2_rs1", bus_if.bpu_rs1, 32'h0000_1000);
    chk("x5_T2_jst", 32'(bus_if.jalr_stall), 0);
    nxt();
    bus_if.ifu_accept = 0;
    @(negedge clk);
    chk("x5_T3_vld", 32'(bus_if.bpu_rs1_vld), 0);
    chk("x5_T3_idx", 32'(bus_if.rf_rd1_idx), 2);
    nxt();

    // x7 with a three-cycle DEP wait
    set_dec(1, 1, 7);
    bus_if.bpu_dep = 1;
    @(negedge clk);
    chk("x7_T_jst", 32'(bus_if.jalr_stall), 1);
    for (int k = 0; k < 3; k++) begin
      nxt();
      if (k == 2) bus_if.bpu_dep = 0;
      @(negedge clk);
      chk("x7_dep_jst", 32'(bus_if.jalr_stall), 1);
      chk("x7_dep_gnt", 32'(bus_if.bpu_gnt), 0);
    end
    nxt();
    @(negedge clk);
    chk("x7_gnt", 32'(bus_if.bpu_gnt), 1);
    chk("x7_idx", 32'(bus_if.rf_rd1_idx), 7);
    nxt();
    set_dec(0, 0, 0);
    bus_if.ifu_accept = 1;
    @(negedge clk);
    chk("x7_rs1", bus_if.bpu_rs1, 32'h7777_0007);
    nxt();
    bus_if.ifu_accept = 0;

    // x9 against a continuous IR request: forced grant on the 5th ARB cycle
    bus_if.ir_rs1_req = 1;
    bus_if.ir_rs1idx  = 3;
    set_dec(1, 1, 9);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      nxt();
      @(negedge clk);
      chk("x9_lost_gnt", 32'(bus_if.bpu_gnt), 0);
      chk("x9_lost_irst", 32'(bus_if.ir_rs1_stall), 0);
      chk("x9_lost_idx", 32'(bus_if.rf_rd1_idx), 3);
    end
    nxt();
    @(negedge clk);
    chk("x9_force_gnt", 32'(bus_if.bpu_gnt), 1);
    chk("x9_force_irst", 32'(bus_if.ir_rs1_stall), 1);
    chk("x9_force_idx", 32'(bus_if.rf_rd1_idx), 9);
    nxt();
    bus_if.ir_rs1_req = 0;
    set_dec(0, 0, 0);
    bus_if.ifu_accept = 1;
    @(negedge clk);
    chk("x9_rs1", bus_if.bpu_rs1, 32'h9999_0009);
    nxt();
    bus_if.ifu_accept = 0;

    // x1, x0 and a non-JALR never leave IDLE
    bus_if.ir_rs1idx = 6;
    for (int r = 0; r < 3; r++) begin
      if (r == 2) set_dec(1, 0, 5);
      else set_dec(1, 1, 5'(1 - r));
      @(negedge clk);
      chk("nox_jst", 32'(bus_if.jalr_stall), 0);
      chk("nox_gnt", 32'(bus_if.bpu_gnt), 0);
      chk("nox_idx", 32'(bus_if.rf_rd1_idx), 6);
      nxt();
      @(negedge clk);
      chk("nox_vld", 32'(bus_if.bpu_rs1_vld), 0);
      chk("nox_jst2", 32'(bus_if.jalr_stall), 0);
      nxt();
    end
    set_dec(0, 0, 0);

    // Flush while losing arbitration, with a request in the flush cycle
    bus_if.ir_rs1_req = 1;
    bus_if.ir_rs1idx  = 4;
    set_dec(1, 1, 9);
    @(negedge clk);
    nxt();
    @(negedge clk);
    nxt();
    bus_if.ifu_flush = 1;
    @(negedge clk);
    chk("flarb_gnt", 32'(bus_if.bpu_gnt), 0);
    chk("flarb_jst", 32'(bus_if.jalr_stall), 1);
    nxt();
    bus_if.ifu_flush = 0;
    set_dec(0, 0, 0);
    @(negedge clk);
    chk("flarb_post_jst", 32'(bus_if.jalr_stall), 0);
    chk("flarb_post_vld", 32'(bus_if.bpu_rs1_vld), 0);
    nxt();
    // Counter must restart from zero: four full losses again
    set_dec(1, 1, 9);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      nxt();
      @(negedge clk);
      chk("restart_lost_gnt", 32'(bus_if.bpu_gnt), 0);
    end
    nxt();
    @(negedge clk);
    chk("restart_gnt", 32'(bus_if.bpu_gnt), 1);
    nxt();
    // Flush in HOLD without accept, new xN request in the same cycle
    bus_if.ir_rs1_req = 0;
    bus_if.ifu_flush  = 1;
    set_dec(1, 1, 5);
    @(negedge clk);
    chk("flhold_vld", 32'(bus_if.bpu_rs1_vld), 1);
    nxt();
    bus_if.ifu_flush = 0;
    set_dec(0, 0, 0);
    @(negedge clk);
    chk("flhold_post_vld", 32'(bus_if.bpu_rs1_vld), 0);
    chk("flhold_post_jst", 32'(bus_if.jalr_stall), 0);
    nxt();
    @(negedge clk);
    chk("flhold_idle_gnt", 32'(bus_if.bpu_gnt), 0);
    chk("flhold_idle_vld", 32'(bus_if.bpu_rs1_vld), 0);
    nxt();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/ifu_jalr_rs1_ctrl.md
Name: ifu_jalr_rs1_ctrl

Overview:
Controller for the shared regfile read port 1 when a JALR's rs1 is neither x0 nor x1 (xN). It sequences the xN read: wait for the dependency to clear, arbitrate read port 1 against the IR/EXU operand read, capture the value, and hold it for the IFU next-PC adder. It sits between the IFU mini-decode/branch-prediction logic and the regfile read port 1 mux. It also raises the IFU stall and, when anti-starvation triggers, the IR stall.

Parameters:
XLEN, 32, data width of regfile read port
RFIDX_WIDTH, 5, register index width
STARVE_MAX, 4, consecutive ARB cycles lost to IR before BPU is forced priority (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
dec_i_valid  input  1  mini-decoded instruction valid
dec_jalr  input  1  instruction is JALR
dec_jalr_rs1idx  input  RFIDX_WIDTH  JALR rs1 index
bpu_dep  input  1  xN dependency present (OITF not empty or IR not NOP)
ifu_flush  input  1  IFU flush/redirect; aborts any sequence
ifu_accept  input  1  IFU consumed the held rs1 value this cycle
ir_rs1_req  input  1  IR/EXU requests read port 1 this cycle
ir_rs1idx  input  RFIDX_WIDTH  IR rs1 index
rf_rd1_data  input  XLEN  regfile read port 1 data (combinational from rf_rd1_idx)
rf_rd1_idx  output  RFIDX_WIDTH  read port 1 index
bpu_gnt  output  1  read port 1 granted to BPU this cycle
ir_rs1_stall  output  1  IR must hold; port 1 taken by BPU
jalr_stall  output  1  IFU must not generate next PC
bpu_rs1_vld  output  1  held rs1 value valid
bpu_rs1  output  XLEN  held rs1 value for next-PC adder op1

Behaviour:
- One clock, rst_n asynchronous active-low. Reset: state=IDLE, starve_cnt=0, rs1_buf=0, bpu_rs1_vld=0, bpu_gnt=0, ir_rs1_stall=0, jalr_stall=0.
- jalr_xn_req = dec_i_valid & dec_jalr & (dec_jalr_rs1idx != 0) & (dec_jalr_rs1idx != 1).
- States: IDLE, DEP, ARB, HOLD (2-bit encoded, registered).
- IDLE: if jalr_xn_req: next = bpu_dep ? DEP : ARB. No grant in IDLE.
- DEP: stay while bpu_dep=1; bpu_dep=0 -> ARB next cycle.
- ARB: bpu_gnt = ~ir_rs1_req | (starve_cnt == STARVE_MAX). On bpu_gnt: rs1_buf <= rf_rd1_data, next = HOLD, starve_cnt <= 0. Else starve_cnt <= starve_cnt+1, stay in ARB.
- Counter width clog2(STARVE_MAX+1); saturates; cleared whenever state != ARB.
- HOLD: bpu_rs1_vld=1, bpu_rs1=rs1_buf; ifu_accept -> IDLE next cycle. Without ifu_accept, stay and keep value stable.
- bpu_rs1 = rs1_buf in all states; meaningful only when bpu_rs1_vld=1.
- rf_rd1_idx = bpu_gnt ? dec_jalr_rs1idx : ir_rs1idx (combinational).
- ir_rs1_stall = (state==ARB) & ir_rs1_req & (starve_cnt==STARVE_MAX).
- jalr_stall = (state==IDLE & jalr_xn_req) | state==DEP | state==ARB. It is 0 in HOLD.
- Latency with no dependency and no contention: request cycle T (IDLE) -> grant T+1 (ARB) -> bpu_rs1_vld at T+2.
- ifu_flush: highest priority. Next state IDLE from any state; starve_cnt cleared; bpu_rs1_vld=0 next cycle. bpu_gnt in the flush cycle is still computed per state, but the captured data is discarded. A jalr_xn_req in the same cycle as ifu_flush is ignored.
- jalr_xn_req while in DEP/ARB/HOLD: ignored. The pending sequence owns the instruction, and dec inputs are held stable by jalr_stall.
- x0/x1 JALR and non-JALR: the block stays IDLE, all outputs inactive, rf_rd1_idx = ir_rs1idx.

Test Plan:
- Reset mid-HOLD (rs1_buf=0xDEADBEEF), assert rst_n=0 asynchronously -> all outputs 0 immediately, state IDLE.
- JALR rs1=x5, bpu_dep=0, ir_rs1_req=0, x5=0x00001000 -> jalr_stall=1 in T and T+1; bpu_gnt=1, rf_rd1_idx=5 at T+1; bpu_rs1_vld=1, bpu_rs1=0x00001000 at T+2; ifu_accept at T+2 -> IDLE at T+3.
- JALR rs1=x7, bpu_dep=1 for 3 cycles -> state DEP for 3 cycles, jalr_stall=1 throughout, bpu_gnt=0; grant one cycle after bpu_dep falls.
- JALR rs1=x9, ir_rs1_req held 1, STARVE_MAX=4 -> bpu_gnt=0 for 4 ARB cycles; 5th ARB cycle bpu_gnt=1 with ir_rs1_stall=1, rf_rd1_idx=9.
- JALR rs1=x1 and rs1=x0 -> state stays IDLE, jalr_stall=0, bpu_gnt=0, rf_rd1_idx follows ir_rs1idx.
- ifu_flush asserted in ARB with ir_rs1_req=1 and in HOLD without ifu_accept -> next cycle IDLE, bpu_rs1_vld=0, starve_cnt=0; a jalr_xn_req in the flush cycle starts no sequence.
